// File: rtl/aes_key_expand_param_if.sv
// Port bundle for the AES key expander: start request, key inputs, round-key read port and status.
// Handshake: start is a single-cycle request, taken on the rising edge where busy is low and key_len is legal; an illegal request pulses err for one cycle and changes nothing else, and a request while busy is dropped silently.
interface aes_key_expand_param_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic         busy;
  logic         key_ready;
  logic         err;
  logic [1:0]   dbg_state;

  modport master (
    output start, key_len, key, rd_round,
    input  round_key, round_key_valid, busy, key_ready, err, dbg_state
  );

  modport slave (
    input  start, key_len, key, rd_round,
    output round_key, round_key_valid, busy, key_ready, err, dbg_state
  );
endinterface

// File: rtl/aes_key_expand_param.sv
// AES-128/192/256 key schedule, one word per cycle into a register bank.
// Round keys are readable as soon as their four words exist.
module aes_key_expand_param #(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 srst_n,
  aes_key_expand_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

  localparam int BANK_WORDS = 4 * (MAX_NK + 7);

  // Byte x of the table sits at bits {~x,3'b111} -: 8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  state_t      state;
  logic        busy_q, ready_q, err_q;
  logic [3:0]  nk;
  logic [5:0]  i_idx;
  logic [2:0]  j_pos;
  logic [7:0]  rcon;
  logic [5:0]  wr_cnt;
  logic [31:0] bank [BANK_WORDS];

  logic [3:0]  nk_req;
  logic        len_ok, can_start, accept;
  logic [5:0]  nw_m1;

  always_comb begin
    case (bus.key_len)
      2'd0:    nk_req = 4'd4;
      2'd1:    nk_req = 4'd6;
      default: nk_req = 4'd8;
    endcase
  end

  assign len_ok    = (bus.key_len != 2'd3) && (nk_req <= 4'(MAX_NK));
  assign can_start = bus.start && (state != EXPAND);
  assign accept    = can_start && len_ok;
  assign nw_m1     = {nk, 2'b00} + 6'd27;

  // Next-word datapath; a single SubWord serves both the j==0 and the Nk==8,j==4 cases.
  logic [5:0]  prev_idx, back_idx;
  logic [31:0] w_prev, w_back, sub_in, sub_out, temp, new_word;
  logic [7:0]  rcon_next;

  always_comb begin
    prev_idx = 6'd0;
    back_idx = 6'd0;
    if (state == EXPAND) begin
      prev_idx = i_idx - 6'd1;
      back_idx = i_idx - {2'b00, nk};
    end
    w_prev  = bank[prev_idx];
    w_back  = bank[back_idx];
    sub_in  = (j_pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (j_pos == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j_pos == 3'd4)
      temp = sub_out;
    else
      temp = w_prev;
    new_word  = w_back ^ temp;
    rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      nk      <= 4'd4;
      i_idx   <= 6'd0;
      j_pos   <= 3'd0;
      rcon    <= 8'h01;
      wr_cnt  <= 6'd0;
    end else begin
      err_q <= can_start && !len_ok;
      if (accept) begin
        state   <= EXPAND;
        busy_q  <= 1'b1;
        ready_q <= 1'b0;
        nk      <= nk_req;
        i_idx   <= {2'b00, nk_req};
        j_pos   <= 3'd0;
        rcon    <= 8'h01;
        wr_cnt  <= {2'b00, nk_req};
      end else if (state == EXPAND) begin
        wr_cnt <= wr_cnt + 6'd1;
        j_pos  <= ({1'b0, j_pos} == nk - 4'd1) ? 3'd0 : j_pos + 3'd1;
        if (j_pos == 3'd0)
          rcon <= rcon_next;
        // i holds at the last word index so it never leaves 0..59.
        if (i_idx == nw_m1) begin
          state   <= DONE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end else begin
          i_idx <= i_idx + 6'd1;
        end
      end
    end
  end

  // Bank has no reset; the written count keeps stale words hidden.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 8; k++)
        if (4'(k) < nk_req)
          bank[k] <= bus.key[255 - 32*k -: 32];
    end else if (state == EXPAND) begin
      bank[i_idx] <= new_word;
    end
  end

  logic       rk_valid;
  logic [5:0] base;

  always_comb begin
    rk_valid = ({1'b0, bus.rd_round, 2'b11} < {1'b0, wr_cnt}) && (bus.rd_round <= nk + 4'd6);
    base     = rk_valid ? {bus.rd_round, 2'b00} : 6'd0;
    bus.round_key = rk_valid ? {bank[base], bank[base + 6'd1], bank[base + 6'd2], bank[base + 6'd3]}
                             : 128'h0;
  end

  assign bus.round_key_valid = rk_valid;
  assign bus.busy            = busy_q;
  assign bus.key_ready       = ready_q;
  assign bus.err             = err_q;
  assign bus.dbg_state       = state;

endmodule

// File: tb/tb_aes_key_expand_param.sv
// Bench for aes_key_expand_param: FIPS-197 key schedules, early round reads, rejects, re-key and reset abort.
module tb_aes_key_expand_param;

  logic clk = 1'b0;
  logic srst_n;
  always #5 clk = ~clk;

  aes_key_expand_param_if bus ();
  aes_key_expand_param_if bus4 ();

  aes_key_expand_param #(.MAX_NK(8)) dut  (.clk(clk), .srst_n(srst_n), .bus(bus.slave));
  aes_key_expand_param #(.MAX_NK(4)) dut4 (.clk(clk), .srst_n(srst_n), .bus(bus4.slave));

  logic [127:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // mode: 0 plain, 1 early-read probe (256), 2 start during EXPAND, 3 reset at E0+20, 4 round-1 boundary (128)
  task automatic run_key(input string tag, input logic [1:0] len, input logic [255:0] k,
                         input logic [3:0] nr, input logic [127:0] final_exp, input int lat,
                         input int mode);
    int n;
    bit done;
    logic [127:0] k0;
    k0 = k[255:128];
    if (mode != 3) exp_q.push_back(final_exp);
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = len; bus.key = k;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.key = rand_key(); bus.key_len = 2'($urandom_range(0, 3));
    bus.rd_round = 4'd0; #1;
    check({tag, " busy_e0"}, bus.busy, 1'b1);
    check({tag, " ready_e0"}, bus.key_ready, 1'b0);
    check({tag, " r0_valid"}, bus.round_key_valid, 1'b1);
    check({tag, " r0_key"}, bus.round_key, k0);
    bus.rd_round = nr; #1;
    check({tag, " rlast_early"}, bus.round_key_valid, 1'b0);
    n = 0; done = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1; n++;
      if (mode == 1 && n == 4) begin
        bus.rd_round = 4'd1; #1;
        check({tag, " r1_valid"}, bus.round_key_valid, 1'b1);
        check({tag, " r1_key"}, bus.round_key, 128'h101112131415161718191a1b1c1d1e1f);
        bus.rd_round = 4'd14; #1;
        check({tag, " r14_invalid"}, bus.round_key_valid, 1'b0);
        check({tag, " r14_zero"}, bus.round_key, 128'h0);
      end
      if (mode == 4 && n == 3) begin
        bus.rd_round = 4'd1; #1;
        check({tag, " r1_not_yet"}, bus.round_key_valid, 1'b0);
      end
      if (mode == 4 && n == 4) begin
        check({tag, " r1_valid"}, bus.round_key_valid, 1'b1);
        check({tag, " r1_key"}, bus.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
      end
      if (mode == 2 && n == 10) begin
        @(negedge clk);
        bus.start = 1'b1; bus.key_len = 2'd0; bus.key = rand_key();
        @(posedge clk); #1; n++;
        bus.start = 1'b0;
        check({tag, " busy_start_no_err"}, bus.err, 1'b0);
        check({tag, " busy_start_still_busy"}, bus.busy, 1'b1);
      end
      if (mode == 3 && n == 20) begin
        srst_n = 1'b0; #1;
        check({tag, " rst_busy"}, bus.busy, 1'b0);
        check({tag, " rst_ready"}, bus.key_ready, 1'b0);
        check({tag, " rst_err"}, bus.err, 1'b0);
        check({tag, " rst_valid"}, bus.round_key_valid, 1'b0);
        check({tag, " rst_key"}, bus.round_key, 128'h0);
        check({tag, " rst_state"}, bus.dbg_state, 2'd0);
        @(negedge clk); srst_n = 1'b1;
        @(posedge clk); #1;
        check({tag, " post_rst_idle"}, bus.dbg_state, 2'd0);
        return;
      end
      if (bus.key_ready) done = 1;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " busy_done"}, bus.busy, 1'b0);
    bus.rd_round = nr; #1;
    check({tag, " rlast_valid"}, bus.round_key_valid, 1'b1);
    check({tag, " rlast_key"}, bus.round_key, exp_q.pop_front());
    bus.rd_round = nr + 4'd1; #1;
    check({tag, " beyond_nr_valid"}, bus.round_key_valid, 1'b0);
    check({tag, " beyond_nr_key"}, bus.round_key, 128'h0);
  endtask

  initial begin
    int n;
    srst_n = 1'b0;
    bus.start = 1'b0;  bus.key_len = 2'd0;  bus.key = '0;  bus.rd_round = 4'd0;
    bus4.start = 1'b0; bus4.key_len = 2'd0; bus4.key = '0; bus4.rd_round = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset ready", bus.key_ready, 1'b0);
    check("reset err", bus.err, 1'b0);
    check("reset valid", bus.round_key_valid, 1'b0);
    check("reset key", bus.round_key, 128'h0);
    check("reset state", bus.dbg_state, 2'd0);
    @(negedge clk); srst_n = 1'b1;

    run_key("s1_aes128", 2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefcafef00d0123456789abcdef},
            4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 40, 4);

    // illegal key_len in DONE: err pulse only
    @(negedge clk); bus.start = 1'b1; bus.key_len = 2'd3; bus.key = rand_key();
    @(posedge clk); #1; bus.start = 1'b0; bus.rd_round = 4'd10; #1;
    check("bad_len err", bus.err, 1'b1);
    check("bad_len busy", bus.busy, 1'b0);
    check("bad_len ready", bus.key_ready, 1'b1);
    check("bad_len state", bus.dbg_state, 2'd2);
    check("bad_len r10", bus.round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk); #1;
    check("bad_len err_one_cycle", bus.err, 1'b0);

    run_key("s2_rekey128", 2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
            4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 40, 0);
    run_key("s3_aes192", 2'd1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h5a5aa5a5f00f0ff0},
            4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, 46, 2);
    run_key("s4_aes256", 2'd2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 52, 1);

    // MAX_NK=4 instance rejects AES-256 and still runs AES-128
    @(negedge clk); bus4.start = 1'b1; bus4.key_len = 2'd2; bus4.key = rand_key();
    @(posedge clk); #1; bus4.start = 1'b0;
    check("nk4 reject err", bus4.err, 1'b1);
    check("nk4 reject busy", bus4.busy, 1'b0);
    check("nk4 reject state", bus4.dbg_state, 2'd0);
    exp_q.push_back(128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(negedge clk); bus4.start = 1'b1; bus4.key_len = 2'd0;
    bus4.key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    @(posedge clk); #1; bus4.start = 1'b0;
    check("nk4 accept err", bus4.err, 1'b0);
    n = 0;
    while (!bus4.key_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("nk4 latency", n, 40);
    bus4.rd_round = 4'd10; #1;
    check("nk4 r10", bus4.round_key, exp_q.pop_front());

    run_key("s6_abort256", 2'd2, rand_key(), 4'd14, 128'h0, 0, 3);
    run_key("s6_after128", 2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
            4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 40, 0);

    check("scoreboard empty", 128'(exp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_param.md
AES_KEY_EXPAND_PARAM -- requirements
Module: aes_key_expand_param

Interface
REQ-001 The block SHALL have parameter MAX_NK, default 8, meaning the largest supported key length in 32-bit words (legal values 4, 6, 8); the key bank SHALL be sized to 4*(MAX_NK+7) words.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port srst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to expand key.
REQ-005 The block SHALL have port key_len, input, 2 bits: 0 = AES-128 (Nk=4, Nr=10), 1 = AES-192 (Nk=6, Nr=12), 2 = AES-256 (Nk=8, Nr=14), 3 = illegal.
REQ-006 The block SHALL have port key, input, 256 bits: cipher key, MSB-aligned; 128-bit keys use key[255:128] and 192-bit keys use key[255:64].
REQ-007 The block SHALL have port rd_round, input, 4 bits: round index to read.
REQ-008 The block SHALL have port round_key, output, 128 bits: bank words 4r..4r+3, with word 4r in bits [127:96].
REQ-009 The block SHALL have port round_key_valid, output, 1 bit: the requested round key is fully written.
REQ-010 The block SHALL have port busy, output, 1 bit: expansion in progress.
REQ-011 The block SHALL have port key_ready, output, 1 bit: all Nr+1 round keys are valid.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-013 The FSM SHALL have states IDLE, EXPAND and DONE; busy SHALL equal (state==EXPAND), and key_ready SHALL equal (state==DONE), both registered.
REQ-014 start SHALL be accepted only in IDLE or DONE, with a legal key_len not exceeding MAX_NK; start in EXPAND SHALL be ignored, with no err.
REQ-015 On the accepting edge E0, the block SHALL latch Nk, write key words w[0..Nk-1] into the bank, set word index i=Nk, set rcon=0x01 and the position counter j=0, and enter EXPAND.
REQ-016 In EXPAND, the block SHALL write exactly one word w[i] per cycle and increment i; there SHALL be no divider, and j SHALL track i mod Nk, wrapping at Nk-1 to 0.
REQ-017 Word rule: temp=w[i-1]; if j==0, temp=SubWord(RotWord(temp))^{rcon,24'h0}, then rcon=xtime(rcon) (poly 0x11b); else if Nk==8 and j==4, temp=SubWord(temp); w[i]=w[i-Nk]^temp.
REQ-018 The block SHALL instantiate a single 32-bit SubWord, built from 4 S-box lookups and shared across all cases.
REQ-019 Total words Nw=4*(Nr+1) SHALL be 44, 52 or 60; the edge writing w[Nw-1] SHALL move the FSM to DONE, so key_ready rises after edge E0+40 (128), E0+46 (192) or E0+52 (256).
REQ-020 round_key SHALL be combinational from rd_round and the bank; round_key_valid SHALL be high iff 4*rd_round+3 < words written so far and rd_round <= Nr; otherwise round_key_valid SHALL be 0 and round_key SHALL be 0.
REQ-021 Early consumption: round 0 SHALL be valid immediately after E0, and round r SHALL be valid as soon as its 4th word is written, without waiting for DONE.
REQ-022 A start with key_len=3, or with Nk > MAX_NK, SHALL pulse err for exactly one cycle and cause no change to state, the bank, key_ready or the valid count.
REQ-023 A start accepted in DONE (re-key) SHALL drop key_ready on E0 and reset the valid count to Nk words, so older rounds SHALL read invalid until rewritten.
REQ-024 key and key_len SHALL be sampled only at E0; later changes SHALL have no effect until the next accepted start.
REQ-025 rcon and all counters SHALL stay within their widths: i is 6 bits with maximum 59, and j is 3 bits.

Reset
REQ-026 While srst_n=0, the block SHALL immediately set state=IDLE, busy=0, key_ready=0, err=0, written count=0, i=0, j=0, Nk=4 and rcon=0x01; round_key_valid SHALL be 0 and round_key SHALL be 0.
REQ-027 Bank contents SHALL NOT require reset, and they SHALL never be visible while invalid.
REQ-028 Reset asserted during EXPAND SHALL abort the expansion; after release, the block SHALL be in IDLE and accept a new start normally.

Verification
REQ-029 Scenario 1: AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready after E0+40; rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 Scenario 2: AES-128 key 000102..0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-031 Scenario 3: AES-192 key 000102..17 -> round 12 = a4970a331a78dc09c418c271e3a41d5d, with key_ready after E0+46.
REQ-032 Scenario 4: AES-256 key 000102..1f -> round 14 = 24fc79ccbf0979e9371ac23c6d68de36, with key_ready after E0+52; during EXPAND, rd_round=1 SHALL be valid from E0+4, while rd_round=14 stays invalid.
REQ-033 Scenario 5: key_len=3, or key_len=2 with MAX_NK=4 -> err high for 1 cycle, busy=0, and state unchanged; start during EXPAND -> ignored, and the original result is still correct.
REQ-034 Scenario 6: srst_n pulsed low at E0+20 of an AES-256 run -> all outputs 0 immediately; a subsequent AES-128 run yields the Scenario 2 result.
